// File: rtl/burst_read_master.sv
// Burst read master: posts bursts over a byte range and buffers returned words in a show-ahead FIFO.
// Optional stop input enabled by defining BURST_READ_MASTER_STOP_EN.
module burst_read_master #(
    parameter int unsigned DATAWIDTH       = 32,
    parameter int unsigned BYTEENABLEWIDTH = 4,
    parameter int unsigned ADDRESSWIDTH    = 32,
    parameter int unsigned MAXBURSTCOUNT   = 4,
    parameter int unsigned BURSTCOUNTWIDTH = 3,
    parameter int unsigned FIFODEPTH       = 32,
    parameter int unsigned FIFODEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       coe_control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    coe_control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    coe_control_read_length,
    input  logic                       coe_control_go,
`ifdef BURST_READ_MASTER_STOP_EN
    input  logic                       coe_control_stop,
`endif
    output logic                       coe_control_done,
    output logic                       coe_control_early_done,
    input  logic                       coe_user_read_buffer,
    output logic [DATAWIDTH-1:0]       coe_user_buffer_data,
    output logic                       coe_user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);

    localparam int unsigned BE_SHIFT = $clog2(BYTEENABLEWIDTH);
    localparam int unsigned PW       = FIFODEPTH_LOG2 + 1;
    localparam int unsigned SW       = FIFODEPTH_LOG2 + 3;

    typedef enum logic [1:0] {IDLE, POST, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [ADDRESSWIDTH-1:0]   address, address_nxt;
    logic [ADDRESSWIDTH-1:0]   length, length_nxt;
    logic                      fixed, fixed_nxt;
    logic [PW-1:0]             reads_pending, pending_nxt;
    logic [PW-1:0]             fifo_used;
    logic [FIFODEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [DATAWIDTH-1:0]      mem [FIFODEPTH];

    logic [ADDRESSWIDTH-1:0]    words_c, burst_bytes_c;
    logic [BURSTCOUNTWIDTH-1:0] burst_c;
    logic space_ok_c, read_c, accept_c, beat_c;
    logic fifo_empty_c, fifo_full_c, fifo_wr_c, fifo_rd_c;

`ifdef BURST_READ_MASTER_STOP_EN
    logic stalled;
`endif

    // Burst sizing and buffer space check, all from registered state
    always_comb begin
        words_c = length >> BE_SHIFT;
        if (words_c >= ADDRESSWIDTH'(MAXBURSTCOUNT))
            burst_c = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);
        else
            burst_c = BURSTCOUNTWIDTH'(words_c);
        burst_bytes_c = ADDRESSWIDTH'(burst_c) << BE_SHIFT;
        space_ok_c = (SW'(fifo_used) + SW'(reads_pending) + SW'(MAXBURSTCOUNT))
                     <= SW'(FIFODEPTH - 1);
    end

`ifdef BURST_READ_MASTER_STOP_EN
    // A request already stalled on waitrequest is kept up until accepted
    assign read_c = (state == POST) && (length != '0) && space_ok_c
                    && (!coe_control_stop || stalled);
`else
    assign read_c = (state == POST) && (length != '0) && space_ok_c;
`endif

    assign accept_c = read_c && !master_waitrequest;
    assign beat_c   = master_readdatavalid && ((reads_pending != '0) || accept_c);

    always_comb begin
        pending_nxt = reads_pending;
        if (accept_c)
            pending_nxt = pending_nxt + PW'(burst_c);
        if (beat_c)
            pending_nxt = pending_nxt - PW'(1);
    end

    // Next-state and transfer register updates
    always_comb begin
        state_nxt   = state;
        address_nxt = address;
        length_nxt  = length;
        fixed_nxt   = fixed;
        case (state)
            IDLE: begin
                if (coe_control_go) begin
                    address_nxt = coe_control_read_base;
                    fixed_nxt   = coe_control_fixed_location;
                    length_nxt  = coe_control_read_length & ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
                end
            end
            POST: begin
                if (accept_c) begin
                    length_nxt = length - burst_bytes_c;
                    if (!fixed)
                        address_nxt = address + burst_bytes_c;
                end
            end
            default: ;
        endcase
`ifdef BURST_READ_MASTER_STOP_EN
        if (coe_control_stop && !(read_c && master_waitrequest)
            && !((state == IDLE) && coe_control_go))
            length_nxt = '0;
`endif
        case (state)
            IDLE:    if (coe_control_go) state_nxt = (length_nxt != '0) ? POST : DRAIN;
            POST:    if (length_nxt == '0) state_nxt = DRAIN;
            DRAIN:   if (reads_pending == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            address       <= '0;
            length        <= '0;
            fixed         <= 1'b0;
            reads_pending <= '0;
`ifdef BURST_READ_MASTER_STOP_EN
            stalled       <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            address       <= address_nxt;
            length        <= length_nxt;
            fixed         <= fixed_nxt;
            reads_pending <= pending_nxt;
`ifdef BURST_READ_MASTER_STOP_EN
            stalled       <= read_c && master_waitrequest;
`endif
        end
    end

    // Show-ahead FIFO; every returned beat is captured regardless of state
    assign fifo_empty_c = (fifo_used == '0);
    assign fifo_full_c  = (fifo_used == PW'(FIFODEPTH));
    assign fifo_rd_c    = coe_user_read_buffer && !fifo_empty_c;
    assign fifo_wr_c    = master_readdatavalid && (!fifo_full_c || fifo_rd_c);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (fifo_wr_c)
                wr_ptr <= wr_ptr + FIFODEPTH_LOG2'(1);
            if (fifo_rd_c)
                rd_ptr <= rd_ptr + FIFODEPTH_LOG2'(1);
            if (fifo_wr_c && !fifo_rd_c)
                fifo_used <= fifo_used + PW'(1);
            else if (fifo_rd_c && !fifo_wr_c)
                fifo_used <= fifo_used - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr_c)
            mem[wr_ptr] <= master_readdata;
    end

    assign coe_user_buffer_data    = mem[rd_ptr];
    assign coe_user_data_available = !fifo_empty_c;
    assign coe_control_done        = (state == IDLE);
    assign coe_control_early_done  = (length == '0);
    assign master_address          = address;
    assign master_read             = read_c;
    assign master_burstcount       = burst_c;
    assign master_byteenable       = '1;

endmodule

// File: tb/tb_burst_read_master.sv
// Directed bench for burst_read_master with a simple in-order slave model.
module tb_burst_read_master;

    logic        clk = 1'b0;
    logic        reset, fixed, go, rb, wr, rdv;
    logic [31:0] base, len, rdata;
    logic        done, early_done, avail, mread;
    logic [31:0] bdata, maddr;
    logic [3:0]  be;
    logic [2:0]  bc;
`ifdef BURST_READ_MASTER_STOP_EN
    logic        stop = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit slave_en = 1'b1;
    logic [31:0] beat_q[$];
    logic [31:0] acc_addr[$];
    int          acc_bc[$];

    always #5 clk = ~clk;

    burst_read_master dut (
        .clk                        (clk),
        .reset                      (reset),
        .coe_control_fixed_location (fixed),
        .coe_control_read_base      (base),
        .coe_control_read_length    (len),
        .coe_control_go             (go),
`ifdef BURST_READ_MASTER_STOP_EN
        .coe_control_stop           (stop),
`endif
        .coe_control_done           (done),
        .coe_control_early_done     (early_done),
        .coe_user_read_buffer       (rb),
        .coe_user_buffer_data       (bdata),
        .coe_user_data_available    (avail),
        .master_address             (maddr),
        .master_read                (mread),
        .master_byteenable          (be),
        .master_burstcount          (bc),
        .master_readdata            (rdata),
        .master_readdatavalid       (rdv),
        .master_waitrequest         (wr)
    );

    // Slave: returns data = beat address, at least one cycle after acceptance
    initial begin
        rdv = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (slave_en && beat_q.size() > 0) begin
                rdv = 1'b1;
                rdata = beat_q.pop_front();
            end else begin
                rdv = 1'b0;
            end
            if (mread && !wr) begin
                acc_addr.push_back(maddr);
                acc_bc.push_back(int'(bc));
                for (int k = 0; k < int'(bc); k++)
                    beat_q.push_back(maddr + 32'(4 * k));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] l, input logic f);
        acc_addr.delete();
        acc_bc.delete();
        base = b;
        len = l;
        fixed = f;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxcyc);
        for (int c = 0; c < maxcyc; c++) begin
            tick();
            if (done) break;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    // Pops until idle and empty; word n is expected to be b + 4*(n % per)
    task automatic pop_check(input string tag, input int exp_n, input logic [31:0] b,
                             input int per, input int maxcyc);
        int n;
        n = 0;
        for (int c = 0; c < maxcyc; c++) begin
            if (avail) begin
                chk({tag, "_data"}, bdata, b + 32'(4 * (n % per)));
                rb = 1'b1;
                n++;
            end else begin
                rb = 1'b0;
            end
            tick();
            if (done && !avail) break;
        end
        rb = 1'b0;
        chk({tag, "_count"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; rb = 1'b0; wr = 1'b0; fixed = 1'b0;
        base = '0; len = '0;
        repeat (3) tick();
        chk("rst_read", 32'(mread), 32'd0);
        chk("rst_addr", maddr, 32'h0);
        chk("rst_bc", 32'(bc), 32'd0);
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_early", 32'(early_done), 32'd1);
        chk("rst_avail", 32'(avail), 32'd0);
        chk("byteenable", 32'(be), 32'hF);
        reset = 1'b1;
        tick();

        // 40 bytes from 0x100: bursts 4,4,2
        start(32'h100, 32'd40, 1'b0);
        chk("s1_busy", 32'(done), 32'd0);
        chk("s1_early_busy", 32'(early_done), 32'd0);
        wait_done("s1_done", 200);
        chk("s1_nbursts", 32'(acc_bc.size()), 32'd3);
        if (acc_bc.size() >= 3) begin
            chk("s1_bc0", 32'(acc_bc[0]), 32'd4);
            chk("s1_bc1", 32'(acc_bc[1]), 32'd4);
            chk("s1_bc2", 32'(acc_bc[2]), 32'd2);
            chk("s1_a0", acc_addr[0], 32'h100);
            chk("s1_a1", acc_addr[1], 32'h110);
            chk("s1_a2", acc_addr[2], 32'h120);
        end
        chk("s1_early_done", 32'(early_done), 32'd1);
        pop_check("s1", 10, 32'h100, 1000, 100);

        // 0x13 bytes: partial final word never requested
        start(32'h200, 32'h13, 1'b0);
        wait_done("s2_done", 200);
        chk("s2_nbursts", 32'(acc_bc.size()), 32'd1);
        if (acc_bc.size() >= 1) begin
            chk("s2_bc0", 32'(acc_bc[0]), 32'd4);
            chk("s2_a0", acc_addr[0], 32'h200);
        end
        pop_check("s2", 4, 32'h200, 1000, 100);

        // Fixed location, 32 bytes
        start(32'h300, 32'd32, 1'b1);
        wait_done("s3_done", 200);
        chk("s3_nbursts", 32'(acc_bc.size()), 32'd2);
        if (acc_bc.size() >= 2) begin
            chk("s3_bc0", 32'(acc_bc[0]), 32'd4);
            chk("s3_bc1", 32'(acc_bc[1]), 32'd4);
            chk("s3_a0", acc_addr[0], 32'h300);
            chk("s3_a1", acc_addr[1], 32'h300);
        end
        pop_check("s3", 8, 32'h300, 4, 100);

        // Waitrequest held for 5 cycles; a go during POST is ignored
        wr = 1'b1;
        start(32'h400, 32'd16, 1'b0);
        chk("s4_read", 32'(mread), 32'd1);
        chk("s4_addr", maddr, 32'h400);
        chk("s4_bc", 32'(bc), 32'd4);
        base = 32'h800;
        len = 32'd64;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s4_hold_read", 32'(mread), 32'd1);
            chk("s4_hold_addr", maddr, 32'h400);
            chk("s4_hold_bc", 32'(bc), 32'd4);
            tick();
        end
        chk("s4_hold_addr_last", maddr, 32'h400);
        wr = 1'b0;
        wait_done("s4_done", 200);
        chk("s4_nbursts", 32'(acc_bc.size()), 32'd1);
        if (acc_bc.size() >= 1)
            chk("s4_a0", acc_addr[0], 32'h400);
        pop_check("s4", 4, 32'h400, 1000, 100);

        // No pops: posting stops at 28 words outstanding, resumes on pops
        start(32'h0, 32'h100, 1'b0);
        repeat (100) tick();
        chk("s5_stall_read", 32'(mread), 32'd0);
        chk("s5_stall_done", 32'(done), 32'd0);
        chk("s5_stall_early", 32'(early_done), 32'd0);
        chk("s5_stall_nbursts", 32'(acc_bc.size()), 32'd7);
        chk("s5_stall_avail", 32'(avail), 32'd1);
        pop_check("s5", 64, 32'h0, 1000, 2000);
        chk("s5_nbursts", 32'(acc_bc.size()), 32'd16);

        // Reset mid-POST with 6 reads outstanding
        slave_en = 1'b0;
        start(32'h500, 32'd64, 1'b0);
        tick();
        tick();
        wr = 1'b1;
        slave_en = 1'b1;
        tick();
        tick();
        slave_en = 1'b0;
        chk("s6_nbursts", 32'(acc_bc.size()), 32'd2);
        chk("s6_pre_read", 32'(mread), 32'd1);
        chk("s6_pre_done", 32'(done), 32'd0);
        chk("s6_pre_avail", 32'(avail), 32'd1);
        reset = 1'b0;
        tick();
        chk("s6_rst_done", 32'(done), 32'd1);
        chk("s6_rst_read", 32'(mread), 32'd0);
        chk("s6_rst_avail", 32'(avail), 32'd0);
        chk("s6_rst_addr", maddr, 32'h0);
        chk("s6_rst_bc", 32'(bc), 32'd0);
        chk("s6_rst_early", 32'(early_done), 32'd1);
        reset = 1'b1;
        wr = 1'b0;
        slave_en = 1'b1;
        repeat (12) tick();
        chk("s6_post_done", 32'(done), 32'd1);
        chk("s6_post_nbursts", 32'(acc_bc.size()), 32'd2);
        pop_check("s6", 6, 32'h508, 1000, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
